mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Parametrised MEM pipeline stage between execute and writeback. Issues loads and stores
//  to a variable-latency RAM over a req/ack handshake. Supports byte/half/word(/dword) sizes
//  with lane steering and byte enables, and sign/zero-extends load data. Stalls the pipeline
//  while a RAM access is outstanding. Reports misaligned, illegal-size and timeout faults.
// PARAMETERS
//  DATA_W    32   RAM/register data width; 32 or 64 (64 enables LD/SD/LWU)
//  REG_W     5    destination register index width
//  TIMEOUT   255  max cycles waiting for mem_ack before bus fault (>=1)
// PORTS
//  clk              in   1         clock; one clock domain
//  rst              in   1         reset, asynchronous, active-low
//  valid_in         in   1         EX stage presents an instruction
//  addr             in   DATA_W    ALU result / effective address
//  data_in          in   DATA_W    store data (rs2)
//  funct3           in   3         access size/sign, RISC-V encoding
//  MemRead          in   1         load
//  MemWrite         in   1         store; MemRead&MemWrite together = illegal size fault
//  in_MemToReg      in   1         passed through
//  in_RegWrite      in   1         passed through; forced 0 on fault or store
//  in_RegDest       in   REG_W     passed through
//  in_PCSrc         in   1         passed through
//  in_BranchTarget  in   DATA_W    passed through
//  mem_ack          in   1         RAM completes current request; mem_rdata valid this cycle
//  mem_rdata        in   DATA_W    RAM read data, aligned word/dword
//  mem_req          out  1         request outstanding (registered)
//  mem_we           out  1         1 = write request
//  mem_addr         out  DATA_W    addr aligned down to DATA_W/8 bytes
//  mem_wdata        out  DATA_W    store data replicated into every lane of its size
//  mem_be           out  DATA_W/8  byte enables (stores); all ones for loads
//  stall_pipeline   out  1         upstream must hold its outputs this cycle
//  valid_out        out  1         registered outputs below are valid this cycle
//  data_out         out  DATA_W    extended load data; 0 for non-loads
//  out_AluResult    out  DATA_W    registered addr
//  out_MemToReg, out_RegWrite, out_RegDest, out_PCSrc, out_BranchTarget  out  registered ctrl
//  out_fault        out  2         00 none, 01 misaligned, 10 bus timeout, 11 illegal size
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE; every registered output and mem_req/mem_we/mem_addr/
//    mem_wdata/mem_be cleared to 0; timeout counter 0. Reset mid-access drops mem_req
//    immediately; a later mem_ack while IDLE is ignored.
//  - FSM IDLE/WAIT. start = valid_in & (MemRead|MemWrite) & no fault.
//    IDLE & start: latch op, mem_req<=1, ->WAIT. WAIT & mem_ack: mem_req<=0, outputs latched,
//    valid_out<=1, ->IDLE. WAIT & cnt==TIMEOUT-1 & !mem_ack: mem_req<=0, out_fault=10, ->IDLE.
//  - stall_pipeline (comb) = (IDLE & start) | (WAIT & !mem_ack & cnt!=TIMEOUT-1).
//  - Non-memory valid_in, or faulting op: 1-cycle registered pass-through, no RAM request.
//  - Memory op latency: mem_req rises 1 cycle after accept; valid_out 1 cycle after mem_ack.
//    Minimum 2 cycles (ack in first req cycle).
//  - valid_out is a 1-cycle pulse per instruction; 0 when valid_in=0 in IDLE.
//  - Alignment: half needs addr[0]=0, word addr[1:0]=0, dword addr[2:0]=0 -> else fault 01.
//  - funct3 011/110 with DATA_W=32, or 111, or MemRead&MemWrite -> fault 11.
//  - On any fault, or store: out_RegWrite=0. Fault has priority 11 over 01.
//  - Store lanes: mem_be = size mask << addr[log2(DATA_W/8)-1:0].
//  - Load: lane = mem_rdata >> 8*offset. LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
// TESTING
//  1 LW addr=0x100, ack after 3 req cycles, rdata=0xDEADBEEF -> stall high 4 cycles;
//    valid_out, data_out=0xDEADBEEF, out_RegWrite=1.
//  2 LB addr=0x103, rdata=0x80112233 -> data_out=0xFFFFFF80; LBU same -> 0x00000080.
//  3 SH addr=0x202, data_in=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1,
//    out_RegWrite=0.
//  4 LW addr=0x101 -> no mem_req, 1-cycle valid_out, out_fault=01.
//  5 LW, no ack for TIMEOUT=4 cycles -> mem_req drops; out_fault=10; stall released.
//  6 rst low while WAIT -> mem_req=0 same cycle; post-reset ack -> no valid_out.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge bus between the MEM stage (master) and a variable-latency RAM (slave).
interface mem_access_stage_if #(
  parameter int DATA_W = 32
);
  logic                mem_req;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores to a variable-latency RAM, steers byte lanes,
// extends load data and reports misaligned / bus-timeout / illegal-size faults.
module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [DATA_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [2:0]          funct3,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic                in_MemToReg,
  input  logic                in_RegWrite,
  input  logic [REG_W-1:0]    in_RegDest,
  input  logic                in_PCSrc,
  input  logic [DATA_W-1:0]   in_BranchTarget,
  mem_access_stage_if.master  mem,
  output logic                stall_pipeline,
  output logic                valid_out,
  output logic [DATA_W-1:0]   data_out,
  output logic [DATA_W-1:0]   out_AluResult,
  output logic                out_MemToReg,
  output logic                out_RegWrite,
  output logic [REG_W-1:0]    out_RegDest,
  output logic                out_PCSrc,
  output logic [DATA_W-1:0]   out_BranchTarget,
  output logic [1:0]          out_fault
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, req_d, we_q, we_d;
  logic [DATA_W-1:0]   maddr_q, maddr_d, wdata_q, wdata_d;
  logic [NB-1:0]       be_q, be_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                vout_q, vout_d;
  logic [DATA_W-1:0]   dout_q, dout_d, alu_q, alu_d, bt_q, bt_d;
  logic                m2r_q, m2r_d, rw_q, rw_d, pcsrc_q, pcsrc_d;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic [1:0]          fault_q, fault_d;

  logic                is_mem, illegal, misaligned, start, stall_c, sign_bit;
  logic [1:0]          fault_in;
  logic [NB-1:0]       size_mask;
  logic [DATA_W-1:0]   wdata_rep, lane, keep, load_ext;

  // Fault decode and store-lane preparation for the instruction currently presented.
  always_comb begin
    is_mem  = MemRead | MemWrite;
    illegal = (MemRead & MemWrite) | (funct3 == 3'b111) |
              ((DATA_W == 32) && ((funct3[1:0] == 2'b11) || (funct3 == 3'b110)));
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      2'b11:   misaligned = |addr[2:0];
      default: misaligned = 1'b0;
    endcase
    fault_in = !is_mem ? 2'b00 : illegal ? 2'b11 : misaligned ? 2'b01 : 2'b00;
    start    = valid_in & is_mem & (fault_in == 2'b00);
    case (funct3[1:0])
      2'b00:   begin size_mask = NB'(1);  wdata_rep = {NB{data_in[7:0]}};        end
      2'b01:   begin size_mask = NB'(3);  wdata_rep = {(NB/2){data_in[15:0]}};   end
      2'b10:   begin size_mask = NB'(15); wdata_rep = {(NB/4){data_in[31:0]}};   end
      default: begin size_mask = '1;      wdata_rep = data_in;                   end
    endcase
  end

  // Load lane extraction: shift the addressed lane down, then sign- or zero-extend.
  always_comb begin
    lane = mem.mem_rdata >> {alu_q[OFF_W-1:0], 3'b000};
    case (size_q)
      2'b00:   begin keep = DATA_W'(8'hFF);         sign_bit = lane[7];  end
      2'b01:   begin keep = DATA_W'(16'hFFFF);      sign_bit = lane[15]; end
      2'b10:   begin keep = DATA_W'(32'hFFFF_FFFF); sign_bit = lane[31]; end
      default: begin keep = '1;                     sign_bit = 1'b0;     end
    endcase
    load_ext = (lane & keep) | ({DATA_W{sign_bit & ~uns_q}} & ~keep);
  end

  always_comb begin
    state_d = state_q;  cnt_d   = cnt_q;    req_d   = req_q;   we_d   = we_q;
    maddr_d = maddr_q;  wdata_d = wdata_q;  be_d    = be_q;    size_d = size_q;
    uns_d   = uns_q;    vout_d  = 1'b0;     dout_d  = dout_q;  alu_d  = alu_q;
    m2r_d   = m2r_q;    rw_d    = rw_q;     rd_d    = rd_q;    pcsrc_d = pcsrc_q;
    bt_d    = bt_q;     fault_d = fault_q;  stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          alu_d   = addr;
          m2r_d   = in_MemToReg;
          rd_d    = in_RegDest;
          pcsrc_d = in_PCSrc;
          bt_d    = in_BranchTarget;
          fault_d = fault_in;
          rw_d    = in_RegWrite & ~MemWrite & (fault_in == 2'b00);
          dout_d  = '0;
          if (start) begin
            stall_c = 1'b1;
            req_d   = 1'b1;
            we_d    = MemWrite;
            maddr_d = {addr[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
            wdata_d = wdata_rep;
            be_d    = MemWrite ? (size_mask << addr[OFF_W-1:0]) : '1;
            size_d  = funct3[1:0];
            uns_d   = funct3[2];
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            vout_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          vout_d  = 1'b1;
          dout_d  = we_q ? '0 : load_ext;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // RAM never answered: retire the instruction as a bus fault.
          req_d   = 1'b0;
          vout_d  = 1'b1;
          fault_d = 2'b10;
          rw_d    = 1'b0;
          dout_d  = '0;
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE; cnt_q   <= '0; req_q   <= 1'b0; we_q   <= 1'b0;
      maddr_q <= '0;     wdata_q <= '0; be_q    <= '0;   size_q <= '0;
      uns_q   <= 1'b0;   vout_q  <= 1'b0; dout_q <= '0;  alu_q  <= '0;
      m2r_q   <= 1'b0;   rw_q    <= 1'b0; rd_q   <= '0;  pcsrc_q <= 1'b0;
      bt_q    <= '0;     fault_q <= '0;
    end else begin
      state_q <= state_d; cnt_q   <= cnt_d;   req_q   <= req_d;   we_q   <= we_d;
      maddr_q <= maddr_d; wdata_q <= wdata_d; be_q    <= be_d;    size_q <= size_d;
      uns_q   <= uns_d;   vout_q  <= vout_d;  dout_q  <= dout_d;  alu_q  <= alu_d;
      m2r_q   <= m2r_d;   rw_q    <= rw_d;    rd_q    <= rd_d;    pcsrc_q <= pcsrc_d;
      bt_q    <= bt_d;    fault_q <= fault_d;
    end
  end

  assign mem.mem_req       = req_q;
  assign mem.mem_we        = we_q;
  assign mem.mem_addr      = maddr_q;
  assign mem.mem_wdata     = wdata_q;
  assign mem.mem_be        = be_q;
  assign stall_pipeline    = stall_c;
  assign valid_out         = vout_q;
  assign data_out          = dout_q;
  assign out_AluResult     = alu_q;
  assign out_MemToReg      = m2r_q;
  assign out_RegWrite      = rw_q;
  assign out_RegDest       = rd_q;
  assign out_PCSrc         = pcsrc_q;
  assign out_BranchTarget  = bt_q;
  assign out_fault         = fault_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage: a behavioural model predicts RAM requests
// and retired results; a RAM responder and an output monitor check them independently.
module tb_mem_access_stage;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] alu;
    logic        m2r;
    logic        rw;
    logic [4:0]  rdst;
    logic        pc;
    logic [31:0] bt;
    logic [1:0]  fault;
  } out_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  ack;
    logic [31:0] rdata;
  } req_t;

  typedef struct {
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a, d;
    logic m2r, rw;
    logic [4:0] rdst;
    logic pc;
    logic [31:0] bt;
    int ack;
    logic [31:0] rdata;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        valid_in = 0, MemRead = 0, MemWrite = 0, in_MemToReg = 0, in_RegWrite = 0, in_PCSrc = 0;
  logic [31:0] addr = 0, data_in = 0, in_BranchTarget = 0;
  logic [2:0]  funct3 = 0;
  logic [4:0]  in_RegDest = 0;
  logic        stall_pipeline, valid_out, out_MemToReg, out_RegWrite, out_PCSrc;
  logic [31:0] data_out, out_AluResult, out_BranchTarget;
  logic [4:0]  out_RegDest;
  logic [1:0]  out_fault;
  logic        ram_ack = 0, force_ack = 0, ram_en = 0;
  logic [31:0] ram_rdata = 0;

  mem_access_stage_if #(.DATA_W(DW)) mif();
  assign mif.mem_ack   = ram_ack | force_ack;
  assign mif.mem_rdata = ram_rdata;

  mem_access_stage #(.DATA_W(DW), .REG_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .addr(addr), .data_in(data_in),
    .funct3(funct3), .MemRead(MemRead), .MemWrite(MemWrite), .in_MemToReg(in_MemToReg),
    .in_RegWrite(in_RegWrite), .in_RegDest(in_RegDest), .in_PCSrc(in_PCSrc),
    .in_BranchTarget(in_BranchTarget), .mem(mif), .stall_pipeline(stall_pipeline),
    .valid_out(valid_out), .data_out(data_out), .out_AluResult(out_AluResult),
    .out_MemToReg(out_MemToReg), .out_RegWrite(out_RegWrite), .out_RegDest(out_RegDest),
    .out_PCSrc(out_PCSrc), .out_BranchTarget(out_BranchTarget), .out_fault(out_fault));

  int   total = 0, passed = 0;
  out_t exp_q[$];
  req_t req_q[$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Reference model: works on byte counts and byte positions rather than masks and shifters.
  function automatic void model(input instr_t in, output out_t o, output logic go,
                                output req_t r, output int stalls);
    int sz, off;
    logic mem, illegal, misal;
    logic [63:0] v;
    sz      = 1 << in.f3[1:0];
    off     = int'(in.a % 4);
    mem     = in.rd | in.wr;
    illegal = mem && ((in.rd && in.wr) || in.f3 == 3 || in.f3 == 6 || in.f3 == 7);
    misal   = mem && ((in.a % sz) != 0);
    o.data  = 0; o.alu = in.a; o.m2r = in.m2r; o.rdst = in.rdst; o.pc = in.pc; o.bt = in.bt;
    o.fault = illegal ? 2'd3 : misal ? 2'd1 : 2'd0;
    o.rw    = in.rw && !in.wr && o.fault == 0;
    go      = mem && o.fault == 0;
    r       = '0;
    stalls  = 0;
    if (go) begin
      r.we    = in.wr;
      r.addr  = in.a & ~32'h3;
      r.be    = in.wr ? 4'(((1 << sz) - 1) << off) : 4'hF;
      for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = in.d[8*(i % sz) +: 8];
      r.ack   = 8'(in.ack);
      r.rdata = in.rdata;
      if (in.ack < 1 || in.ack > TO) begin
        stalls  = TO;
        o.fault = 2'd2;
        o.rw    = 1'b0;
      end else begin
        stalls = in.ack;
        if (!in.wr) begin
          v = 0;
          for (int i = 0; i < sz; i++) v[8*i +: 8] = in.rdata[8*(off + i) +: 8];
          if (!in.f3[2] && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 1);
          o.data = v[31:0];
        end
      end
    end
  endfunction

  function automatic instr_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] d,
                                input int ack, input logic [31:0] rdata);
    instr_t t;
    t.rd = rd; t.wr = wr; t.f3 = f3; t.a = a; t.d = d; t.ack = ack; t.rdata = rdata;
    t.m2r = 1'b1; t.rw = 1'b1; t.rdst = 5'(a[4:0] ^ 5'd7); t.pc = a[5]; t.bt = ~a;
    return t;
  endfunction

  task automatic issue(input instr_t in);
    out_t o;
    req_t r;
    logic go;
    int   exp_stalls, n;
    model(in, o, go, r, exp_stalls);
    exp_q.push_back(o);
    if (go) req_q.push_back(r);
    @(negedge clk);
    valid_in = 1; MemRead = in.rd; MemWrite = in.wr; funct3 = in.f3; addr = in.a;
    data_in = in.d; in_MemToReg = in.m2r; in_RegWrite = in.rw; in_RegDest = in.rdst;
    in_PCSrc = in.pc; in_BranchTarget = in.bt;
    n = 0;
    #1;
    while (stall_pipeline && n < 64) begin
      n++;
      @(negedge clk);
      #1;
    end
    $display("issue rd=%0b wr=%0b f3=%0d addr=%h ack=%0d stalls=%0d", in.rd, in.wr, in.f3, in.a, in.ack, n);
    check("stall_cycles", 160'(n), 160'(exp_stalls));
    @(posedge clk);
  endtask

  task automatic bubble();
    @(negedge clk);
    valid_in = 0; MemRead = 1'($urandom); MemWrite = 1'($urandom); addr = $urandom;
    @(posedge clk);
  endtask

  // Output monitor: every valid_out must match the oldest predicted result.
  always @(negedge clk) begin
    out_t act, e;
    if (rst && valid_out) begin
      act = {data_out, out_AluResult, out_MemToReg, out_RegWrite, out_RegDest, out_PCSrc,
             out_BranchTarget, out_fault};
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid_out: got valid_out=1 data=%h fault=%0d, required no output", data_out, out_fault);
      end else begin
        e = exp_q.pop_front();
        $display("retire data=%h fault=%0d rw=%0b", data_out, out_fault, out_RegWrite);
        check("retired_result", 160'(act), 160'(e));
      end
    end
  end

  // RAM responder: checks each new request and acknowledges after the chosen number of cycles.
  initial begin
    req_t cur;
    logic in_req;
    int   n, exp_len;
    in_req = 0; n = 0; cur = '0;
    forever begin
      @(negedge clk);
      ram_ack = 0;
      if (!rst || !ram_en) begin
        in_req = 0;
      end else if (mif.mem_req) begin
        if (!in_req) begin
          in_req = 1;
          n = 0;
          if (req_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_mem_req: got mem_req=1 addr=%h, required no request", mif.mem_addr);
          end else begin
            cur = req_q.pop_front();
            check("mem_request", 160'({mif.mem_we, mif.mem_addr, mif.mem_be, mif.mem_wdata}),
                  160'({cur.we, cur.addr, cur.be, cur.wdata}));
          end
        end
        n++;
        if (cur.ack != 0 && n == int'(cur.ack)) begin
          ram_ack = 1;
          ram_rdata = cur.rdata;
        end else begin
          ram_rdata = $urandom;
        end
      end else if (in_req) begin
        in_req = 0;
        exp_len = (cur.ack >= 1 && cur.ack <= TO) ? int'(cur.ack) : TO;
        check("req_length", 160'(n), 160'(exp_len));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t t;
    int k;
    repeat (2) @(negedge clk);
    check("reset_mem_req", 160'(mif.mem_req), 160'(0));
    check("reset_valid_out", 160'(valid_out), 160'(0));
    check("reset_bus", 160'({mif.mem_we, mif.mem_addr, mif.mem_wdata, mif.mem_be}), 160'(0));
    check("reset_outputs", 160'({data_out, out_AluResult, out_RegWrite, out_fault, stall_pipeline}), 160'(0));
    rst = 1; ram_en = 1;

    issue(mk(1, 0, 3'b010, 32'h100, 0, 4, 32'hDEADBEEF));
    issue(mk(1, 0, 3'b000, 32'h103, 0, 2, 32'h80112233));
    issue(mk(1, 0, 3'b100, 32'h103, 0, 1, 32'h80112233));
    issue(mk(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 3, 0));
    issue(mk(1, 0, 3'b010, 32'h101, 0, 1, 0));
    issue(mk(1, 0, 3'b010, 32'h104, 0, 0, 0));
    issue(mk(1, 0, 3'b011, 32'h108, 0, 1, 0));
    issue(mk(1, 1, 3'b010, 32'h10C, 0, 1, 0));
    issue(mk(0, 0, 3'b111, 32'h55, 0, 1, 0));
    bubble();
    bubble();

    // Reset while a load is waiting: the request must vanish and a late ack must be ignored.
    ram_en = 0;
    @(negedge clk);
    valid_in = 1; MemRead = 1; MemWrite = 0; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk);
    @(negedge clk);
    valid_in = 0; MemRead = 0;
    @(negedge clk);
    check("req_before_reset", 160'(mif.mem_req), 160'(1));
    check("stall_before_reset", 160'(stall_pipeline), 160'(1));
    rst = 0;
    #1;
    check("req_dropped_by_reset", 160'(mif.mem_req), 160'(0));
    check("stall_in_reset", 160'(stall_pipeline), 160'(0));
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    force_ack = 1;
    @(negedge clk);
    force_ack = 0;
    repeat (2) @(negedge clk);
    check("no_req_after_late_ack", 160'(mif.mem_req), 160'(0));
    ram_en = 1;

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      t = mk(k >= 2 && k <= 5 || k == 9, k >= 6, 3'($urandom_range(0, 7)),
             $urandom, $urandom, $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 4) != 0) begin
        if (t.rd && !t.wr) t.f3 = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5));
        if (t.wr) t.f3 = 3'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 3) != 0) t.a = t.a & ~((32'd1 << t.f3[1:0]) - 1);
      t.m2r = 1'($urandom); t.rw = 1'($urandom); t.rdst = 5'($urandom);
      t.pc = 1'($urandom); t.bt = $urandom;
      issue(t);
      if ($urandom_range(0, 3) == 0) bubble();
    end
    repeat (4) bubble();
    check("results_drained", 160'(exp_q.size()), 160'(0));
    check("requests_drained", 160'(req_q.size()), 160'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
